hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage pipeline; sits beside the ID stage and drives the PC, IF/ID and ID/EXE pipeline registers.
- Keeps a shadow copy of destination-register info for the EXE and MEM stages.
- Each cycle it:
  - detects load-use hazards and inserts a one-cycle stall plus bubble;
  - generates ALU operand forwarding selects;
  - flushes IF/ID on a taken branch.
- Also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall, ALU operand forwarding and branch flush
//               control for the 5-stage pipeline, with saturating counters.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             br_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idexe_bubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic             r_ex_valid;
    logic             r_ex_wreg;
    logic             r_ex_m2reg;
    logic [RA_W-1:0]  r_ex_rd;
    logic             r_mem_valid;
    logic             r_mem_wreg;
    logic             r_mem_m2reg;
    logic [RA_W-1:0]  r_mem_rd;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_ex_rs;
    logic w_ex_rt;
    logic w_mem_rs;
    logic w_mem_rt;
    logic w_load_use;

    // Register 0 is hard-wired, so a producer targeting it never matches.
    assign w_ex_rs  = r_ex_valid  & r_ex_wreg  & (r_ex_rd  != '0) & (r_ex_rd  == id_rs);
    assign w_ex_rt  = r_ex_valid  & r_ex_wreg  & (r_ex_rd  != '0) & (r_ex_rd  == id_rt);
    assign w_mem_rs = r_mem_valid & r_mem_wreg & (r_mem_rd != '0) & (r_mem_rd == id_rs);
    assign w_mem_rt = r_mem_valid & r_mem_wreg & (r_mem_rd != '0) & (r_mem_rd == id_rt);

    assign w_load_use = id_valid & r_ex_m2reg &
                        ((id_use_rs & w_ex_rs) | (id_use_rt & w_ex_rt));

    function automatic logic [1:0] fwd_sel(input logic use_op, input logic ex_hit,
                                           input logic ex_ld, input logic mem_hit,
                                           input logic mem_ld);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_op) begin
            if (ex_hit && !ex_ld)
                sel = 2'b01;
            else if (mem_hit)
                sel = mem_ld ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idexe_bubble = 1'b0;
        ifid_flush   = br_taken;
        fwda         = 2'b00;
        fwdb         = 2'b00;
        if (w_load_use) begin
            // Stall wins over a coincident branch; ID re-presents it next cycle.
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idexe_bubble = 1'b1;
            ifid_flush   = 1'b0;
        end else if (id_valid) begin
            fwda = fwd_sel(id_use_rs, w_ex_rs, r_ex_m2reg, w_mem_rs, r_mem_m2reg);
            fwdb = fwd_sel(id_use_rt, w_ex_rt, r_ex_m2reg, w_mem_rt, r_mem_m2reg);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_wreg   <= 1'b0;
            r_ex_m2reg  <= 1'b0;
            r_ex_rd     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_wreg  <= 1'b0;
            r_mem_m2reg <= 1'b0;
            r_mem_rd    <= '0;
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_wreg  <= r_ex_wreg;
            r_mem_m2reg <= r_ex_m2reg;
            r_mem_rd    <= r_ex_rd;
            if (idexe_bubble) begin
                r_ex_valid <= 1'b0;
                r_ex_wreg  <= 1'b0;
                r_ex_m2reg <= 1'b0;
                r_ex_rd    <= '0;
            end else begin
                r_ex_valid <= id_valid;
                r_ex_wreg  <= id_wreg;
                r_ex_m2reg <= id_m2reg;
                r_ex_rd    <= id_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_load_use && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            if (ifid_flush && (r_flush_cnt != c_cnt_max))
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl with directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 8;
    localparam int RA_W  = 5;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [RA_W-1:0]  id_rd;
    logic             id_wreg;
    logic             id_m2reg;
    logic             br_taken;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idexe_bubble;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    hazard_ctrl #(.CNT_W(CNT_W), .RA_W(RA_W)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_rd        (id_rd),
        .id_wreg      (id_wreg),
        .id_m2reg     (id_m2reg),
        .br_taken     (br_taken),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idexe_bubble (idexe_bubble),
        .fwda         (fwda),
        .fwdb         (fwdb),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [7:0]       ctl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [CNT_W-1:0] exp_sc   = '0;
    logic [CNT_W-1:0] exp_fc   = '0;

    // Monitor: outputs are combinational, so one expectation is retired per cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = sb_q.pop_front();
            act = {pc_we, ifid_we, ifid_flush, idexe_bubble, fwda, fwdb};
            n_checks++;
            if (act !== e.ctl || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                n_errors++;
                $display("FAIL %s: got ctl=%b sc=%0d fc=%0d, want ctl=%b sc=%0d fc=%0d",
                         e.name, act, stall_cnt, flush_cnt, e.ctl, e.sc, e.fc);
            end
        end
    end

    // One pipeline cycle: drive ID, optionally hit async reset, queue the expectation.
    task automatic cyc(input string name, input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urs, input logic urt,
                       input logic [4:0] rd, input logic wr, input logic m2,
                       input logic br, input logic e_stall, input logic e_flush,
                       input logic [1:0] e_fa, input logic [1:0] e_fb,
                       input logic do_rst);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;
        id_rd = rd;    id_wreg = wr; id_m2reg = m2; br_taken = br;
        if (do_rst) begin
            #1;
            rst    = 1'b1;
            exp_sc = '0;
            exp_fc = '0;
        end
        e.name = name;
        e.ctl  = {~e_stall, ~e_stall, e_flush, e_stall, e_fa, e_fb};
        e.sc   = exp_sc;
        e.fc   = exp_fc;
        sb_q.push_back(e);
        if (e_stall && exp_sc != {CNT_W{1'b1}}) exp_sc = exp_sc + 1'b1;
        if (e_flush && exp_fc != {CNT_W{1'b1}}) exp_fc = exp_fc + 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_rd = 0; id_wreg = 0; id_m2reg = 0; br_taken = 0;

        //    name          v rs rt urs urt rd wr m2 br  stl fl fa     fb  rst
        cyc("reset_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        @(posedge clk); #1 rst = 1'b0;
        cyc("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);

        cyc("ex_prod",      1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("ex_fwd",       1, 5, 5, 1, 0, 0, 0, 0, 0,  0, 0, 2'b01, 2'b00, 0);

        cyc("mem_prod",     1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("mem_indep",    1, 1, 2, 0, 0, 8, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("mem_fwd",      1, 5, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2'b10, 2'b00, 0);

        cyc("ld_prod",      1, 0, 0, 0, 0, 5, 1, 1, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("ld_indep",     1, 0, 0, 0, 0, 8, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("mem_ld_fwd",   1, 5, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2'b11, 2'b00, 0);

        cyc("lu_load",      1, 0, 0, 0, 0, 7, 1, 1, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("lu_stall",     1, 0, 7, 0, 1, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0);
        cyc("lu_after",     1, 0, 7, 0, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b11, 0);

        cyc("prio_mem",     1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("prio_ex",      1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("prio_fwd",     1, 9, 9, 1, 1, 0, 0, 0, 0,  0, 0, 2'b01, 2'b01, 0);

        cyc("r0_load",      1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("r0_use",       1, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);

        cyc("br_flush",     1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 2'b00, 2'b00, 0);
        cyc("br_cnt",       0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("brlu_load",    1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("brlu_stall",   1, 4, 0, 1, 0, 0, 0, 0, 1,  1, 0, 2'b00, 2'b00, 0);
        cyc("brlu_retry",   1, 4, 0, 1, 0, 0, 0, 0, 1,  0, 1, 2'b11, 2'b00, 0);
        cyc("brlu_cnt",     0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);

        cyc("inv_prod",     1, 0, 0, 0, 0, 6, 1, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("inv_fwd",      0, 6, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("inv_load",     1, 0, 0, 0, 0, 6, 1, 1, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("inv_lu",       0, 6, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);

        // Reset lands between the stall appearing and the next clock edge.
        cyc("rst_load",     1, 0, 0, 0, 0, 7, 1, 1, 0,  0, 0, 2'b00, 2'b00, 0);
        cyc("rst_midstall", 1, 0, 7, 0, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1);
        cyc("rst_hold",     1, 0, 7, 0, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);
        @(posedge clk); #1 rst = 1'b0;
        cyc("rst_after",    1, 3, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);

        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            cyc("sat_load", 1, 0, 0, 0, 0, 7, 1, 1, 0,  0, 0, 2'b00, 2'b00, 0);
            cyc("sat_stall",1, 0, 7, 0, 1, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0);
        end
        cyc("sat_final",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0);

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        n_checks++;
        if (exp_sc != {CNT_W{1'b1}}) begin
            n_errors++;
            $display("FAIL sat_model: got %0d, want %0d", exp_sc, {CNT_W{1'b1}});
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
